// File: rtl/iic_xfer_pkg.sv
// Shared definitions for the I2C transfer sequencer: FSM states, byte-engine
// command encoding and the default transfer length limit.
package iic_xfer_pkg;

    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WR    = 3'd3,
        ST_RD    = 3'd4,
        ST_STOP  = 3'd5,
        ST_FIN   = 3'd6
    } xfer_state_e;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_READ_ACK  = 3'd2,
        CMD_READ_NACK = 3'd3,
        CMD_STOP      = 3'd4
    } be_cmd_e;

    function automatic logic req_len_legal(input logic [4:0] len, input int max_len);
        return (len != 5'd0) && (int'(len) <= max_len);
    endfunction

    // The final byte of a read is NACKed so the slave releases SDA before STOP
    function automatic be_cmd_e read_cmd(input logic [4:0] remaining);
        return (remaining == 5'd1) ? CMD_READ_NACK : CMD_READ_ACK;
    endfunction

endpackage

// File: rtl/iic_xfer_seq.sv
// I2C transfer sequencer: turns one request into START / address / data / STOP
// commands for an external byte engine, one command outstanding at a time.
module iic_xfer_seq
    import iic_xfer_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic       req_rw,
    input  logic [4:0] req_len,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    input  logic [7:0] wdata,
    output logic       rdata_valid,
    output logic [7:0] rdata,
    output logic       done,
    output logic       nack,
    output logic       err,
    output logic       busy,
    output logic       be_cmd_valid,
    input  logic       be_cmd_ready,
    output logic [2:0] be_cmd,
    output logic [7:0] be_txd,
    input  logic       be_rsp_valid,
    input  logic [7:0] be_rxd,
    input  logic       be_ack
);

    xfer_state_e state_r;
    be_cmd_e     cmd_r;
    logic [6:0]  addr_r;
    logic        rw_r;
    logic [4:0]  cnt_r;
    logic        wait_rsp_r;
    logic        cmd_valid_r;
    logic [7:0]  txd_r;
    logic        req_ready_r;
    logic        wdata_ready_r;
    logic        rdata_valid_r;
    logic [7:0]  rdata_r;
    logic        done_r;
    logic        nack_r;
    logic        err_r;
    logic        busy_r;
    logic        rsp_s;

    // A response counts only while a command has been accepted and not yet answered
    assign rsp_s = wait_rsp_r && be_rsp_valid;

    assign req_ready    = req_ready_r;
    assign wdata_ready  = wdata_ready_r;
    assign rdata_valid  = rdata_valid_r;
    assign rdata        = rdata_r;
    assign done         = done_r;
    assign nack         = nack_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign be_cmd_valid = cmd_valid_r;
    assign be_cmd       = cmd_r;
    assign be_txd       = txd_r;

    // Sequencer FSM: request intake, command handshake and response handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cmd_r         <= CMD_START;
            addr_r        <= 7'd0;
            rw_r          <= 1'b0;
            cnt_r         <= 5'd0;
            wait_rsp_r    <= 1'b0;
            cmd_valid_r   <= 1'b0;
            txd_r         <= 8'd0;
            req_ready_r   <= 1'b1;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_r       <= 8'd0;
            done_r        <= 1'b0;
            nack_r        <= 1'b0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            rdata_valid_r <= 1'b0;

            if (cmd_valid_r && be_cmd_ready) begin
                cmd_valid_r <= 1'b0;
                wait_rsp_r  <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        if (req_len_legal(req_len, MAX_LEN)) begin
                            addr_r      <= req_addr;
                            rw_r        <= req_rw;
                            cnt_r       <= req_len;
                            busy_r      <= 1'b1;
                            nack_r      <= 1'b0;
                            req_ready_r <= 1'b0;
                            state_r     <= ST_START;
                            cmd_valid_r <= 1'b1;
                            cmd_r       <= CMD_START;
                            txd_r       <= 8'd0;
                        end else begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    if (rsp_s) begin
                        wait_rsp_r  <= 1'b0;
                        state_r     <= ST_ADDR;
                        cmd_valid_r <= 1'b1;
                        cmd_r       <= CMD_WRITE;
                        txd_r       <= {addr_r, rw_r};
                    end
                end

                ST_ADDR: begin
                    if (rsp_s) begin
                        wait_rsp_r <= 1'b0;
                        if (!be_ack) begin
                            nack_r      <= 1'b1;
                            state_r     <= ST_STOP;
                            cmd_valid_r <= 1'b1;
                            cmd_r       <= CMD_STOP;
                            txd_r       <= 8'd0;
                        end else if (rw_r) begin
                            state_r     <= ST_RD;
                            cmd_valid_r <= 1'b1;
                            cmd_r       <= read_cmd(cnt_r);
                            txd_r       <= 8'd0;
                        end else begin
                            state_r       <= ST_WR;
                            wdata_ready_r <= 1'b1;
                        end
                    end
                end

                ST_WR: begin
                    // wdata_ready and a pending response never overlap
                    if (wdata_ready_r && wdata_valid) begin
                        wdata_ready_r <= 1'b0;
                        cmd_valid_r   <= 1'b1;
                        cmd_r         <= CMD_WRITE;
                        txd_r         <= wdata;
                    end
                    if (rsp_s) begin
                        wait_rsp_r <= 1'b0;
                        if (!be_ack) begin
                            nack_r      <= 1'b1;
                            state_r     <= ST_STOP;
                            cmd_valid_r <= 1'b1;
                            cmd_r       <= CMD_STOP;
                            txd_r       <= 8'd0;
                        end else if (cnt_r == 5'd1) begin
                            cnt_r       <= 5'd0;
                            state_r     <= ST_STOP;
                            cmd_valid_r <= 1'b1;
                            cmd_r       <= CMD_STOP;
                            txd_r       <= 8'd0;
                        end else begin
                            cnt_r         <= cnt_r - 5'd1;
                            wdata_ready_r <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (rsp_s) begin
                        wait_rsp_r    <= 1'b0;
                        rdata_valid_r <= 1'b1;
                        rdata_r       <= be_rxd;
                        cmd_valid_r   <= 1'b1;
                        txd_r         <= 8'd0;
                        if (cnt_r == 5'd1) begin
                            cnt_r   <= 5'd0;
                            state_r <= ST_STOP;
                            cmd_r   <= CMD_STOP;
                        end else begin
                            cnt_r <= cnt_r - 5'd1;
                            cmd_r <= read_cmd(cnt_r - 5'd1);
                        end
                    end
                end

                ST_STOP: begin
                    if (rsp_s) begin
                        wait_rsp_r <= 1'b0;
                        state_r    <= ST_FIN;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end

                ST_FIN: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                end

                default: begin
                    state_r       <= ST_IDLE;
                    cmd_valid_r   <= 1'b0;
                    wait_rsp_r    <= 1'b0;
                    wdata_ready_r <= 1'b0;
                    busy_r        <= 1'b0;
                    req_ready_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_xfer_seq.sv
// Randomised bench for iic_xfer_seq: a byte-engine responder plus a transfer-level
// model of the expected command stream, read data and status.
`timescale 1ns/1ps
module tb_iic_xfer_seq;

    localparam logic [2:0] C_START = 3'd0;
    localparam logic [2:0] C_WRITE = 3'd1;
    localparam logic [2:0] C_RACK  = 3'd2;
    localparam logic [2:0] C_RNACK = 3'd3;
    localparam logic [2:0] C_STOP  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_addr = 7'd0;
    logic       req_rw = 1'b0;
    logic [4:0] req_len = 5'd0;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic [7:0] rdata;
    logic       done, nack, err, busy;
    logic       be_cmd_valid;
    logic       be_cmd_ready;
    logic [2:0] be_cmd;
    logic [7:0] be_txd;
    logic       be_rsp_valid;
    logic [7:0] be_rxd;
    logic       be_ack;

    always #5 clk = ~clk;

    iic_xfer_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .done(done), .nack(nack), .err(err), .busy(busy),
        .be_cmd_valid(be_cmd_valid), .be_cmd_ready(be_cmd_ready),
        .be_cmd(be_cmd), .be_txd(be_txd),
        .be_rsp_valid(be_rsp_valid), .be_rxd(be_rxd), .be_ack(be_ack)
    );

    int total = 0;
    int bad = 0;

    logic [10:0] log_q[$];
    logic [10:0] exp_cmd_q[$];
    logic [7:0]  wq[$];
    bit          ack_q[$];
    logic [7:0]  rxd_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  got_rd_q[$];
    bit          exp_nack;
    bit          exp_wr_phase;
    int          n_reads;
    int done_cnt, err_cnt, wr_rdy_cyc, cmdv_cyc, rrdy_low_cyc, stop_cnt;
    int stall_cfg = 0;
    int gap_cfg = 0;
    int gap_left = 0;
    bit spur_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-engine responder, write-data source and per-cycle output monitor
    initial begin : engine
        bit outst;
        bit prev_hold;
        logic [2:0] pcmd;
        logic [2:0] ocmd;
        logic [7:0] ptxd;
        logic [7:0] rx;
        int rsp_wait;
        int stall_left;
        outst = 1'b0; prev_hold = 1'b0; pcmd = 3'd0; ocmd = 3'd0; ptxd = 8'd0;
        rsp_wait = 0; stall_left = 0;
        be_cmd_ready = 1'b0; be_rsp_valid = 1'b0; be_rxd = 8'd0; be_ack = 1'b0;
        wdata_valid = 1'b0; wdata = 8'd0;
        forever begin
            @(negedge clk);
            be_rsp_valid = 1'b0;
            if (!rst_n) begin
                outst = 1'b0; prev_hold = 1'b0; rsp_wait = 0; stall_left = stall_cfg;
                be_cmd_ready = 1'b0; wdata_valid = 1'b0;
                check("reset_req_ready", 32'(req_ready), 32'd1);
                check("reset_outputs", 32'({busy, done, err, nack, be_cmd_valid, wdata_ready, rdata_valid}), 32'd0);
            end else begin
                if (rdata_valid) begin
                    got_rd_q.push_back(rdata);
                    if (exp_rd_q.size() == 0) check("rdata_extra", 32'd1, 32'd0);
                    else check("rdata", 32'(rdata), 32'(exp_rd_q.pop_front()));
                end
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (wdata_ready) wr_rdy_cyc++;
                if (be_cmd_valid) cmdv_cyc++;
                if (!req_ready) rrdy_low_cyc++;
                if (prev_hold)
                    check("cmd_hold", 32'({be_cmd_valid, be_cmd, be_txd}), 32'({1'b1, pcmd, ptxd}));
                if (outst) check("one_outstanding", 32'(be_cmd_valid), 32'd0);
                if (wdata_ready) check("wready_bus_idle", 32'(be_cmd_valid | outst), 32'd0);

                if (outst) begin
                    if (rsp_wait > 0) rsp_wait--;
                    else begin
                        be_rsp_valid = 1'b1;
                        outst = 1'b0;
                        if (ocmd == C_WRITE) begin
                            be_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b1;
                            be_rxd = 8'($urandom);
                        end else if (ocmd == C_RACK || ocmd == C_RNACK) begin
                            rx = (rxd_q.size() > 0) ? rxd_q.pop_front() : 8'($urandom);
                            be_rxd = rx;
                            be_ack = 1'($urandom);
                            exp_rd_q.push_back(rx);
                        end else begin
                            be_ack = 1'($urandom);
                            be_rxd = 8'($urandom);
                        end
                    end
                end else if (spur_en && $urandom_range(0, 5) == 0) begin
                    be_rsp_valid = 1'b1;
                    be_ack = 1'($urandom);
                    be_rxd = 8'($urandom);
                end

                if (be_cmd_valid) begin
                    if (stall_left > 0) begin
                        be_cmd_ready = 1'b0;
                        stall_left--;
                    end else begin
                        be_cmd_ready = 1'b1;
                        log_q.push_back({be_cmd, be_txd});
                        outst = 1'b1;
                        ocmd = be_cmd;
                        rsp_wait = $urandom_range(0, 2);
                        stall_left = stall_cfg;
                        if (be_cmd == C_STOP) stop_cnt++;
                    end
                end else begin
                    be_cmd_ready = 1'($urandom);
                end
                prev_hold = be_cmd_valid && !be_cmd_ready;
                pcmd = be_cmd;
                ptxd = be_txd;

                if (wq.size() > 0) begin
                    if (gap_left > 0) begin
                        wdata_valid = 1'b0;
                        if (wdata_ready) gap_left--;
                    end else begin
                        wdata_valid = 1'b1;
                        wdata = wq[0];
                        if (wdata_ready) begin
                            void'(wq.pop_front());
                            gap_left = gap_cfg;
                        end
                    end
                end else begin
                    wdata_valid = 1'b0;
                end
            end
        end
    end

    // Transfer-level model: what the bus must see for this request
    task automatic prep(input logic [6:0] addr, input bit rw, input logic [4:0] len,
                        input bit addr_ack, input logic [15:0] nmask);
        bit legal;
        legal = (len != 5'd0) && (len <= 5'd16);
        log_q.delete(); got_rd_q.delete(); exp_rd_q.delete(); ack_q.delete(); exp_cmd_q.delete();
        done_cnt = 0; err_cnt = 0; wr_rdy_cyc = 0; cmdv_cyc = 0; rrdy_low_cyc = 0; stop_cnt = 0;
        gap_left = gap_cfg;
        if (legal && !rw) begin
            if (wq.size() == 0)
                for (int i = 0; i < int'(len); i++) wq.push_back(8'($urandom));
        end else begin
            wq.delete();
        end
        exp_nack = 1'b0;
        exp_wr_phase = legal && !rw && addr_ack;
        n_reads = (legal && rw && addr_ack) ? int'(len) : 0;
        if (legal) begin
            ack_q.push_back(addr_ack);
            for (int i = 0; i < int'(len); i++) ack_q.push_back(!nmask[i]);
            exp_cmd_q.push_back({C_START, 8'h00});
            exp_cmd_q.push_back({C_WRITE, addr, rw});
            if (!addr_ack) exp_nack = 1'b1;
            else if (rw) begin
                for (int i = 0; i < int'(len); i++)
                    exp_cmd_q.push_back({(i == int'(len) - 1) ? C_RNACK : C_RACK, 8'h00});
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    exp_cmd_q.push_back({C_WRITE, wq[i]});
                    if (nmask[i]) begin
                        exp_nack = 1'b1;
                        break;
                    end
                end
            end
            exp_cmd_q.push_back({C_STOP, 8'h00});
        end
    endtask

    task automatic send_req(input logic [6:0] addr, input bit rw, input logic [4:0] len);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_rw = rw; req_len = len;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 7'($urandom); req_rw = 1'($urandom); req_len = 5'($urandom);
        check("busy_after_accept", 32'(busy), 32'((len != 5'd0) && (len <= 5'd16)));
    endtask

    task automatic run_xfer(input logic [6:0] addr, input bit rw, input logic [4:0] len,
                            input bit addr_ack, input logic [15:0] nmask);
        int cyc;
        prep(addr, rw, len, addr_ack, nmask);
        send_req(addr, rw, len);
        if (exp_cmd_q.size() == 0) begin
            repeat (4) @(negedge clk);
            check("illegal_err", 32'(err_cnt), 32'd1);
            check("illegal_done", 32'(done_cnt), 32'd1);
            check("illegal_no_cmd", 32'(cmdv_cyc), 32'd0);
            check("illegal_ready_held", 32'(rrdy_low_cyc), 32'd0);
        end else begin
            cyc = 0;
            while (done_cnt == 0 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check("done_seen", 32'(done_cnt > 0), 32'd1);
            repeat (3) @(negedge clk);
            check("done_once", 32'(done_cnt), 32'd1);
            check("no_err", 32'(err_cnt), 32'd0);
            check("nack", 32'(nack), 32'(exp_nack));
            check("busy_end", 32'(busy), 32'd0);
            check("ready_end", 32'(req_ready), 32'd1);
            check("stop_once", 32'(stop_cnt), 32'd1);
            check("cmd_count", 32'(log_q.size()), 32'(exp_cmd_q.size()));
            for (int i = 0; i < exp_cmd_q.size() && i < log_q.size(); i++) begin
                if (exp_cmd_q[i][10:8] == C_WRITE)
                    check("cmd_write", 32'(log_q[i]), 32'(exp_cmd_q[i]));
                else
                    check("cmd_kind", 32'(log_q[i][10:8]), 32'(exp_cmd_q[i][10:8]));
            end
            check("read_count", 32'(got_rd_q.size()), 32'(n_reads));
            if (!exp_wr_phase) check("no_wready", 32'(wr_rdy_cyc), 32'd0);
        end
        wq.delete();
        rxd_q.delete();
    endtask

    task automatic reset_mid_read();
        int cyc;
        bit saw_read;
        prep(7'h50, 1'b1, 5'd3, 1'b1, 16'h0000);
        send_req(7'h50, 1'b1, 5'd3);
        saw_read = 1'b0;
        cyc = 0;
        while (!saw_read && cyc < 500) begin
            @(negedge clk);
            cyc++;
            foreach (log_q[i]) if (log_q[i][10:8] == C_RACK) saw_read = 1'b1;
        end
        check("reached_rd", 32'(saw_read), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_stop", 32'(stop_cnt), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_ready_after", 32'(req_ready), 32'd1);
        exp_rd_q.delete();
        rxd_q.delete();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [4:0]  len;
        logic [15:0] nmask;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        wq = {8'hA5, 8'h3C};
        run_xfer(7'h50, 1'b0, 5'd2, 1'b1, 16'h0000);
        check("w_addr_byte", 32'(log_q[1]), 32'h1A0);
        check("w_data0", 32'(log_q[2]), 32'h1A5);
        check("w_data1", 32'(log_q[3]), 32'h13C);
        check("w_nack0", 32'(nack), 32'd0);

        rxd_q = {8'h11, 8'h22, 8'h33};
        run_xfer(7'h50, 1'b1, 5'd3, 1'b1, 16'h0000);
        check("r_addr_byte", 32'(log_q[1]), 32'h1A1);
        check("r_last_nack", 32'(log_q[4][10:8]), 32'd3);
        check("r_data0", 32'(got_rd_q[0]), 32'h11);
        check("r_data2", 32'(got_rd_q[2]), 32'h33);

        run_xfer(7'h50, 1'b0, 5'd4, 1'b0, 16'h0000);
        check("an_cmds", 32'(log_q.size()), 32'd3);
        check("an_stop", 32'(log_q[2][10:8]), 32'd4);
        check("an_nack", 32'(nack), 32'd1);
        check("an_wready", 32'(wr_rdy_cyc), 32'd0);

        run_xfer(7'h50, 1'b0, 5'd0, 1'b1, 16'h0000);
        run_xfer(7'h50, 1'b1, 5'd17, 1'b1, 16'h0000);

        stall_cfg = 5;
        gap_cfg = 3;
        run_xfer(7'h2B, 1'b0, 5'd3, 1'b1, 16'h0000);
        stall_cfg = 0;
        gap_cfg = 0;

        reset_mid_read();
        run_xfer(7'h50, 1'b1, 5'd3, 1'b1, 16'h0000);

        run_xfer(7'h11, 1'b0, 5'd16, 1'b1, 16'h0000);
        run_xfer(7'h22, 1'b0, 5'd5, 1'b1, 16'h0004);

        spur_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
            else
                len = 5'($urandom_range(1, 16));
            for (int b = 0; b < 16; b++) nmask[b] = ($urandom_range(0, 9) == 0);
            stall_cfg = $urandom_range(0, 2);
            gap_cfg = $urandom_range(0, 2);
            run_xfer(7'($urandom), 1'($urandom), len, $urandom_range(0, 7) != 0, nmask);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
